// File: rtl/branch_fwd_hazard_unit_pkg.sv
// Shared constants for the branch forwarding / hazard unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bfu_pkg;

    // Operand source select for the ID-stage branch comparator muxes.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Stall FSM state encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Number of stall cycles a single source needs before it is forwardable.
    localparam logic [1:0] NEED_NONE = 2'd0;
    localparam logic [1:0] NEED_ONE  = 2'd1;
    localparam logic [1:0] NEED_TWO  = 2'd2;

endpackage

// File: rtl/branch_fwd_hazard_unit_if.sv
// Bundle between the ID stage and the branch forwarding / hazard unit.
// Latency: n/a (wires only).
// Backpressure: stall is the only flow-control signal; it holds PC and IF/ID.
// Ports: id_branch/id_src/flush and the three producer stages in; fwd_sel, stall,
// busy out. With BFU_STATS_EN defined, stat_stalls and stat_fwds are added.
interface branch_fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic                       id_branch;
    logic [NUM_SRC*REG_AW-1:0]  id_src;
    logic                       flush;
    logic                       idex_wr;
    logic [REG_AW-1:0]          idex_rd;
    logic                       idex_load;
    logic                       exmem_wr;
    logic [REG_AW-1:0]          exmem_rd;
    logic                       exmem_load;
    logic                       memwb_wr;
    logic [REG_AW-1:0]          memwb_rd;
    logic [NUM_SRC*2-1:0]       fwd_sel;
    logic                       stall;
    logic                       busy;
`ifdef BFU_STATS_EN
    logic [31:0]                stat_stalls;
    logic [31:0]                stat_fwds;
`endif

    // Pipeline side: drives ID/producer state, consumes select and stall.
    modport master (
        output id_branch, id_src, flush,
        output idex_wr, idex_rd, idex_load,
        output exmem_wr, exmem_rd, exmem_load,
        output memwb_wr, memwb_rd,
        input  fwd_sel, stall, busy
`ifdef BFU_STATS_EN
        , input stat_stalls, stat_fwds
`endif
    );

    // Hazard unit side.
    modport slave (
        input  id_branch, id_src, flush,
        input  idex_wr, idex_rd, idex_load,
        input  exmem_wr, exmem_rd, exmem_load,
        input  memwb_wr, memwb_rd,
        output fwd_sel, stall, busy
`ifdef BFU_STATS_EN
        , output stat_stalls, stat_fwds
`endif
    );

endinterface

// File: rtl/branch_fwd_hazard_unit_src_check.sv
// Per-source producer match, forward select and stall-need for one branch operand.
// Latency: purely combinational.
// Backpressure: none; need feeds the stall FSM in the top level.
// Ports: src index plus the three producer stages in; sel (mux select) and need out.
module bfu_src_check
    import bfu_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              idex_wr,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_load,
    input  logic              exmem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_load,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        sel,
    output logic [1:0]        need
);

    // A nonzero rd equal to src also implies src is nonzero, so the zero
    // register can never match.
    logic m_idex, m_exmem, m_memwb;

    assign m_idex  = idex_wr  && (idex_rd  != '0) && (idex_rd  == src);
    assign m_exmem = exmem_wr && (exmem_rd != '0) && (exmem_rd == src);
    assign m_memwb = memwb_wr && (memwb_rd != '0) && (memwb_rd == src);

    // A load in EX/MEM has no data yet, so it falls through to MEM/WB (which
    // is then an older, stale write) and the need logic stalls instead.
    always_comb begin
        sel = FWD_RF;
        if (m_exmem && !exmem_load) begin
            sel = FWD_EXMEM;
        end else if (m_memwb) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        need = NEED_NONE;
        if (m_idex) begin
            need = idex_load ? NEED_TWO : NEED_ONE;
        end else if (m_exmem && exmem_load) begin
            need = NEED_ONE;
        end
    end

endmodule

// File: rtl/branch_fwd_hazard_unit.sv
// ID-stage branch operand forwarding plus a registered stall FSM for the MIPS pipeline.
// Latency: fwd_sel/stall combinational from inputs; busy registered (HOLD state).
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; flush overrides it at once.
// Ports: clock, reset (async, active-high) and bus (slave modport of the interface).
// Optional macro BFU_STATS_EN adds stat_stalls / stat_fwds cycle counters.
module branch_fwd_hazard_unit
    import bfu_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    branch_fwd_hazard_unit_if.slave   bus
);

    logic [NUM_SRC*2-1:0] sel_raw;
    logic [1:0]           src_need [NUM_SRC];
    logic [1:0]           need;
    logic [1:0]           need_m1;
    logic [0:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic                 stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        bfu_src_check #(
            .REG_AW (REG_AW)
        ) u_chk (
            .src        (bus.id_src[g*REG_AW +: REG_AW]),
            .idex_wr    (bus.idex_wr),
            .idex_rd    (bus.idex_rd),
            .idex_load  (bus.idex_load),
            .exmem_wr   (bus.exmem_wr),
            .exmem_rd   (bus.exmem_rd),
            .exmem_load (bus.exmem_load),
            .memwb_wr   (bus.memwb_wr),
            .memwb_rd   (bus.memwb_rd),
            .sel        (sel_raw[g*2 +: 2]),
            .need       (src_need[g])
        );
    end

    // Worst-case need over all sources; only a live branch can stall.
    always_comb begin
        need = NEED_NONE;
        if (bus.id_branch) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_need[i] > need) begin
                    need = src_need[i];
                end
            end
        end
    end

    assign need_m1 = need - 2'd1;

    always_comb begin
        stall = 1'b0;
        if (bus.flush) begin
            stall = 1'b0;
        end else if (state == ST_HOLD) begin
            stall = 1'b1;
        end else begin
            stall = (need != NEED_NONE);
        end
    end

    // IDLE covers the first stall cycle itself; HOLD only counts the remainder.
    // Leaving HOLD always goes through IDLE so the hazard is re-evaluated,
    // e.g. a load that has only reached EX/MEM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (need != NEED_NONE) begin
                        cnt <= CNT_W'(need_m1);
                        if (need_m1 != 2'd0) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.fwd_sel = bus.id_branch ? sel_raw : '0;
    assign bus.stall   = stall;
    assign bus.busy    = (state == ST_HOLD);

`ifdef BFU_STATS_EN
    logic [31:0] stat_stalls_q;
    logic [31:0] stat_fwds_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_stalls_q <= '0;
            stat_fwds_q   <= '0;
        end else begin
            if (stall) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
            if (bus.id_branch && !stall && (bus.fwd_sel != '0)) begin
                stat_fwds_q <= stat_fwds_q + 32'd1;
            end
        end
    end

    assign bus.stat_stalls = stat_stalls_q;
    assign bus.stat_fwds   = stat_fwds_q;
`endif

endmodule

// File: tb/tb_branch_fwd_hazard_unit.sv
// Directed bench for branch_fwd_hazard_unit: a default (2 src, 5-bit) instance
// and a 3 src / 6-bit instance; expectations queued at drive, checked at negedge.
module tb_branch_fwd_hazard_unit;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    branch_fwd_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2)) bif_a ();
    branch_fwd_hazard_unit_if #(.REG_AW(6), .NUM_SRC(3)) bif_b ();

    branch_fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .CNT_W(2)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bif_a)
    );

    branch_fwd_hazard_unit #(.REG_AW(6), .NUM_SRC(3), .CNT_W(2)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bif_b)
    );

    typedef struct packed {
        logic       dut_b;
        logic       st;
        logic       bz;
        logic       chkf;
        logic [7:0] fw;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned exp_stalls = 0;
    int unsigned exp_fwds   = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic br, input logic [4:0] s0, input logic [4:0] s1,
                           input logic fl,
                           input logic iw, input logic [4:0] ir, input logic il,
                           input logic ew, input logic [4:0] er, input logic el,
                           input logic mw, input logic [4:0] mr);
        bif_a.id_branch  = br;
        bif_a.id_src     = {s1, s0};
        bif_a.flush      = fl;
        bif_a.idex_wr    = iw;
        bif_a.idex_rd    = ir;
        bif_a.idex_load  = il;
        bif_a.exmem_wr   = ew;
        bif_a.exmem_rd   = er;
        bif_a.exmem_load = el;
        bif_a.memwb_wr   = mw;
        bif_a.memwb_rd   = mr;
    endtask

    task automatic drive_b(input logic br, input logic [5:0] s0, input logic [5:0] s1,
                           input logic [5:0] s2, input logic fl,
                           input logic iw, input logic [5:0] ir, input logic il,
                           input logic ew, input logic [5:0] er, input logic el,
                           input logic mw, input logic [5:0] mr);
        bif_b.id_branch  = br;
        bif_b.id_src     = {s2, s1, s0};
        bif_b.flush      = fl;
        bif_b.idex_wr    = iw;
        bif_b.idex_rd    = ir;
        bif_b.idex_load  = il;
        bif_b.exmem_wr   = ew;
        bif_b.exmem_rd   = er;
        bif_b.exmem_load = el;
        bif_b.memwb_wr   = mw;
        bif_b.memwb_rd   = mr;
    endtask

    // Queue the expected outputs for the A instance and update the stats model.
    task automatic expect_a(input string tag, input logic st, input logic bz,
                            input logic chkf, input logic [3:0] fw);
        exp_t e;
        e.dut_b = 1'b0; e.st = st; e.bz = bz; e.chkf = chkf; e.fw = {4'b0, fw};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (st) exp_stalls++;
        if (bif_a.id_branch && !st && (fw != 4'b0)) exp_fwds++;
    endtask

    task automatic expect_b(input string tag, input logic st, input logic bz,
                            input logic chkf, input logic [5:0] fw);
        exp_t e;
        e.dut_b = 1'b1; e.st = st; e.bz = bz; e.chkf = chkf; e.fw = {2'b0, fw};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Compare all queued expectations at the falling edge, then advance to
    // just after the next rising edge where the next stimulus is applied.
    task automatic tick();
        exp_t  e;
        string t;
        @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (!e.dut_b) begin
                cmp({t, ".stall"}, {31'b0, bif_a.stall}, {31'b0, e.st});
                cmp({t, ".busy"},  {31'b0, bif_a.busy},  {31'b0, e.bz});
                if (e.chkf) cmp({t, ".fwd"}, {28'b0, bif_a.fwd_sel}, {24'b0, e.fw});
            end else begin
                cmp({t, ".stall"}, {31'b0, bif_b.stall}, {31'b0, e.st});
                cmp({t, ".busy"},  {31'b0, bif_b.busy},  {31'b0, e.bz});
                if (e.chkf) cmp({t, ".fwd"}, {26'b0, bif_b.fwd_sel}, {24'b0, e.fw});
            end
        end
        @(posedge clock);
        #1;
    endtask

`ifdef BFU_STATS_EN
    task automatic check_stats(input string tag);
        cmp({tag, ".stat_stalls"}, bif_a.stat_stalls, exp_stalls);
        cmp({tag, ".stat_fwds"},   bif_a.stat_fwds,   exp_fwds);
    endtask
`endif

    initial begin
        reset = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        expect_a("reset", 0, 0, 1, 4'b0000);
        expect_b("reset_b", 0, 0, 1, 6'b0);
        tick();
`ifdef BFU_STATS_EN
        check_stats("reset");
`endif
        reset = 1'b0;

        // No branch in ID: matches present but nothing stalls or forwards.
        drive_a(0, 8, 0, 0, 1, 8, 0, 1, 8, 0, 0, 0);
        expect_a("nobr", 0, 0, 1, 4'b0000); tick();

        // ALU producer in ID/EX: one stall, then forward from EX/MEM.
        drive_a(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0);
        expect_a("alu_c1", 1, 0, 0, 4'b0); tick();
        drive_a(1, 8, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        expect_a("alu_rel", 0, 0, 1, 4'b0010); tick();

        // Load in ID/EX on src1: two stalls (second in HOLD), release via MEM/WB.
        drive_a(1, 0, 9, 0, 1, 9, 1, 0, 0, 0, 0, 0);
        expect_a("ld_c1", 1, 0, 0, 4'b0); tick();
        drive_a(1, 0, 9, 0, 0, 0, 0, 1, 9, 1, 0, 0);
        expect_a("ld_c2", 1, 1, 0, 4'b0); tick();
        drive_a(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        expect_a("ld_rel", 0, 0, 1, 4'b0100); tick();

        // Load in EX/MEM: one stall without entering HOLD.
        drive_a(1, 7, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        expect_a("exld_c1", 1, 0, 0, 4'b0); tick();
        drive_a(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        expect_a("exld_rel", 0, 0, 1, 4'b0001); tick();

        // Same register in EX/MEM and MEM/WB: EX/MEM wins.
        drive_a(1, 5, 0, 0, 0, 0, 0, 1, 5, 0, 1, 5);
        expect_a("dbl", 0, 0, 1, 4'b0010); tick();

        // Register 0 everywhere never matches, even as a load.
        drive_a(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0);
        expect_a("zero", 0, 0, 1, 4'b0000); tick();

        // Different sources resolved independently.
        drive_a(1, 3, 4, 0, 0, 0, 0, 1, 3, 0, 1, 4);
        expect_a("indep", 0, 0, 1, 4'b0110); tick();

        // Write enables low on ID/EX and EX/MEM: only MEM/WB matches.
        drive_a(1, 6, 6, 0, 0, 6, 1, 0, 6, 0, 1, 6);
        expect_a("wr_off", 0, 0, 1, 4'b0101); tick();

        // Load hazard without a branch is ignored.
        drive_a(0, 9, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0);
        expect_a("nobr_ld", 0, 0, 1, 4'b0000); tick();

        // Need is the max over sources: src0 needs 1, src1 needs 2.
        drive_a(1, 12, 13, 0, 1, 13, 1, 1, 12, 1, 0, 0);
        expect_a("max_c1", 1, 0, 0, 4'b0); tick();
        drive_a(1, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_a("max_c2", 1, 1, 0, 4'b0); tick();
        drive_a(1, 12, 13, 0, 0, 0, 0, 0, 0, 0, 1, 13);
        expect_a("max_rel", 0, 0, 1, 4'b0100); tick();

        // Flush in HOLD: stall drops that cycle, busy clears the next.
        drive_a(1, 9, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0);
        expect_a("fl_c1", 1, 0, 0, 4'b0); tick();
        drive_a(1, 9, 0, 1, 0, 0, 0, 1, 9, 1, 0, 0);
        expect_a("fl_hold", 0, 1, 1, 4'b0000); tick();
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_a("fl_after", 0, 0, 1, 4'b0000); tick();

        // Flush in IDLE with a load hazard: no stall and no entry into HOLD.
        drive_a(1, 8, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        expect_a("fl_idle", 0, 0, 1, 4'b0000); tick();
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_a("fl_idle_n", 0, 0, 1, 4'b0000); tick();
`ifdef BFU_STATS_EN
        check_stats("mid");
`endif

        // Reset asserted mid-cycle while in HOLD aborts at once.
        drive_a(1, 9, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0);
        expect_a("rst_c1", 1, 0, 0, 4'b0); tick();
        reset = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_stalls = 0;
        exp_fwds   = 0;
        expect_a("rst_hold", 0, 0, 1, 4'b0000); tick();
`ifdef BFU_STATS_EN
        check_stats("rst");
`endif
        reset = 1'b0;

        // Fresh ALU stall after the abort starts from IDLE.
        drive_a(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0);
        expect_a("post_rst_c1", 1, 0, 0, 4'b0); tick();
        drive_a(1, 8, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        expect_a("post_rst_rel", 0, 0, 1, 4'b0010); tick();
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Wider instance: src2 = 63 hit by a load in ID/EX.
        drive_b(1, 1, 2, 63, 0, 1, 63, 1, 1, 1, 0, 0, 0);
        expect_b("b_c1", 1, 0, 0, 6'b0); tick();
        drive_b(1, 1, 2, 63, 0, 0, 0, 0, 1, 63, 1, 0, 0);
        expect_b("b_c2", 1, 1, 0, 6'b0); tick();
        drive_b(1, 1, 2, 63, 0, 0, 0, 0, 1, 1, 0, 1, 63);
        expect_b("b_rel", 0, 0, 1, 6'b010010); tick();
        drive_b(1, 1, 2, 63, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        expect_b("b_src1", 0, 0, 1, 6'b000100); tick();
        drive_b(1, 31, 0, 0, 0, 1, 63, 1, 0, 0, 0, 0, 0);
        expect_b("b_trunc", 0, 0, 1, 6'b000000); tick();
`ifdef BFU_STATS_EN
        check_stats("final");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_fwd_hazard_unit.md
Name: branch_fwd_hazard_unit

Overview:
- ID-stage branch operand forwarding and stall controller for the MIPS pipeline.
- Successor to the two-source combinational branch forwarder. Generalised in register-index width and source-operand count.
- Adds a registered stall FSM that holds a branch in ID until every source is forwardable from EX/MEM or MEM/WB.
- Sits beside the ID stage; drives the ID operand muxes and the PC/IF-ID write enables.

Parameters:
- REG_AW, 5: register index width; index 0 is the hardwired zero register.
- NUM_SRC, 2: number of branch source operands checked (1..4).
- CNT_W, 2: stall counter width; must hold max stall count 2.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- id_branch  in  1  valid branch/jr in ID needing operands this cycle
- id_src  in  NUM_SRC*REG_AW  packed source indices; src i at [i*REG_AW +: REG_AW]
- flush  in  1  redirect/exception; kills the ID instruction
- idex_wr, idex_rd, idex_load  in  1, REG_AW, 1  ID/EX producer: write enable, dest, is-load
- exmem_wr, exmem_rd, exmem_load  in  1, REG_AW, 1  EX/MEM producer
- memwb_wr, memwb_rd  in  1, REG_AW  MEM/WB producer
- fwd_sel  out  NUM_SRC*2  per source: 2'b10 = EX/MEM, 2'b01 = MEM/WB, 2'b00 = register file
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- busy  out  1  FSM in HOLD

Behaviour:
- Match rules:
  - Match(stage, i) = stage_wr && stage_rd != 0 && stage_rd == src_i.
  - Sources equal to 0 never match.
- Forward select, combinational, per source:
  - EX/MEM match and not exmem_load -> 10.
  - Else MEM/WB match -> 01.
  - Else 00.
  - EX/MEM takes priority over MEM/WB.
- Per-source stall need n_i:
  - 2 if ID/EX match and idex_load.
  - 1 if ID/EX match (ALU producer).
  - 1 if EX/MEM match and exmem_load.
  - 0 otherwise.
  - ID/EX match takes priority over EX/MEM.
- need = max over i of n_i, evaluated only when id_branch = 1.
- FSM states: IDLE, HOLD; counter cnt of width CNT_W.
- IDLE:
  - stall = id_branch && need > 0 && !flush.
  - If stall: cnt <= need - 1; go to HOLD if need - 1 > 0, else stay in IDLE.
  - After a need = 1 stall the inputs are re-evaluated in the next cycle.
- HOLD:
  - stall = 1; hazard inputs ignored.
  - cnt decrements each cycle; at cnt == 1 the next state is IDLE with cnt = 0.
  - The inputs are then re-evaluated in IDLE. This covers a load that has moved on to EX/MEM and still needs 1 more cycle.
- flush:
  - Any state -> IDLE, cnt <= 0.
  - stall = 0 in the same cycle (combinational override).
- busy = (state == HOLD).
- fwd_sel is valid whenever stall = 0. It is don't-care but stable while stalling.
- Reset: state = IDLE, cnt = 0, stall = 0, busy = 0. fwd_sel = 0 while id_branch = 0.
  - Asserting reset mid-HOLD aborts immediately.
- Latency summary:
  - ALU producer in ID/EX: 1 stall cycle.
  - Load in ID/EX: 2 stall cycles, then EX/MEM... forwarding is not used for it; the value arrives via MEM/WB select 01 in the release cycle.
  - Load in EX/MEM: 1 stall cycle.
- Simultaneous matches:
  - Different sources on different stages are resolved independently.
  - The same register in both EX/MEM and MEM/WB selects the EX/MEM source.

Optional Feature:
- Macro: BFU_STATS_EN.
- Defined:
  - Adds outputs stat_stalls[31:0] and stat_fwds[31:0].
  - stat_stalls counts cycles with stall = 1.
  - stat_fwds counts cycles with id_branch && !stall && any fwd_sel != 0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bfu_pkg holds:
  - FWD_RF = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10;
  - the state encoding (IDLE = 0, HOLD = 1);
  - the stall-need constants.
- One sub-module, bfu_src_check: per-source match/need/select logic, instantiated NUM_SRC times via generate.
- The FSM and the max-reduction stay in the top level.

Test Plan:
- ALU stall: id_branch = 1, src0 = 8; idex_wr = 1, idex_rd = 8, idex_load = 0 -> stall = 1 for exactly 1 cycle. Next cycle, with exmem_rd = 8: stall = 0, fwd_sel[1:0] = 10.
- Load then branch: idex_rd = 9, idex_load = 1 on src1 -> stall = 1 for 2 cycles, busy = 1 in cycle 2. Release with memwb_rd = 9: fwd_sel[3:2] = 01.
- Double match: exmem_rd = memwb_rd = 5, src0 = 5 -> fwd_sel[1:0] = 10, stall = 0. Register 0 in every stage with src = 0 -> fwd_sel = 0, stall = 0.
- Flush mid-HOLD: enter HOLD via load hazard, assert flush -> stall = 0 that cycle, busy = 0 next cycle. Repeat with reset -> immediate IDLE, all outputs 0.
- Parameter sweep: NUM_SRC = 3, REG_AW = 6; src2 = 63 matching a load in ID/EX -> 2-cycle stall; other sources unaffected.
- BFU_STATS_EN: after the scenarios above, stat_stalls equals the bench's count of stall cycles and stat_fwds matches the bench's count of forwarded branches.
